// File: rtl/lda_pkg.sv
// Shared LDA definitions: classifier dimensions, coefficient type, frame layout, loader states.
// LDA_LOADER_CSUM_EN adds the trailing checksum byte and the CSUM loader state.
package lda_pkg;

    localparam int DIMS    = 6;
    localparam int CLASSES = 3;

    typedef logic [7:0] T;

    localparam T   SYNC  = 8'hA5;
    localparam int N_WGT = DIMS * CLASSES;

`ifdef LDA_LOADER_CSUM_EN
    localparam int FRAME_LEN = 1 + N_WGT + CLASSES + 1;
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_WGT,
        LD_THR,
        LD_CSUM,
        LD_COMMIT
    } ld_state_t;
`else
    localparam int FRAME_LEN = 1 + N_WGT + CLASSES;
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_WGT,
        LD_THR,
        LD_COMMIT
    } ld_state_t;
`endif

endpackage

// File: rtl/lda_coef_loader.sv
// Coefficient loader: byte-stream frames fill a shadow bank that is committed atomically to the
// active bank feeding the classifier. LDA_LOADER_CSUM_EN enables the checksum byte and check.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// LD_IDLE   | hunting for SYNC, other bytes dropped
// LD_WGT    | receiving DIMS*CLASSES weights, class-outer / dim-inner
// LD_THR    | receiving CLASSES thresholds
// LD_CSUM   | receiving checksum byte (LDA_LOADER_CSUM_EN only)
// LD_COMMIT | ready low for one cycle, shadow copied to active bank
module lda_coef_loader
    import lda_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  T     byte_i,
    input  logic valid_i,
    output logic ready_o,
    output T     w_o [DIMS][CLASSES],
    output T     c_o [CLASSES],
    output logic coef_valid_o,
    output logic busy_o,
    output logic load_done_o,
    output logic load_err_o
);

    localparam int DW = $clog2(DIMS);
    localparam int CW = $clog2(CLASSES);
    localparam logic [DW-1:0] DIM_LAST = DW'(DIMS - 1);
    localparam logic [CW-1:0] CLS_LAST = CW'(CLASSES - 1);

    ld_state_t     state;
    logic [DW-1:0] dim_idx;
    logic [CW-1:0] cls_idx;
    T              sh_w [DIMS][CLASSES];
    T              sh_c [CLASSES];
    logic          xfer;

    assign xfer   = valid_i & ready_o;
    assign busy_o = (state != LD_IDLE);

`ifdef LDA_LOADER_CSUM_EN
    T acc;
    T acc_next;
    assign acc_next = acc + byte_i;
`else
    assign load_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= LD_IDLE;
            dim_idx      <= '0;
            cls_idx      <= '0;
            sh_w         <= '{default: '0};
            sh_c         <= '{default: '0};
            w_o          <= '{default: '0};
            c_o          <= '{default: '0};
            coef_valid_o <= 1'b0;
            ready_o      <= 1'b0;
            load_done_o  <= 1'b0;
`ifdef LDA_LOADER_CSUM_EN
            acc          <= '0;
            load_err_o   <= 1'b0;
`endif
        end else begin
            ready_o     <= 1'b1;
            load_done_o <= 1'b0;
`ifdef LDA_LOADER_CSUM_EN
            load_err_o  <= 1'b0;
`endif
            // Abort wins over a same-cycle byte; the shadow keeps its partial contents.
            if (clear_i) begin
                state   <= LD_IDLE;
                dim_idx <= '0;
                cls_idx <= '0;
            end else begin
                case (state)
                    LD_IDLE: begin
                        if (xfer && byte_i == SYNC) begin
                            state   <= LD_WGT;
                            dim_idx <= '0;
                            cls_idx <= '0;
`ifdef LDA_LOADER_CSUM_EN
                            acc     <= SYNC;
`endif
                        end
                    end
                    LD_WGT: begin
                        if (xfer) begin
                            sh_w[dim_idx][cls_idx] <= byte_i;
`ifdef LDA_LOADER_CSUM_EN
                            acc <= acc_next;
`endif
                            if (dim_idx == DIM_LAST) begin
                                dim_idx <= '0;
                                if (cls_idx == CLS_LAST) begin
                                    cls_idx <= '0;
                                    state   <= LD_THR;
                                end else begin
                                    cls_idx <= cls_idx + 1'b1;
                                end
                            end else begin
                                dim_idx <= dim_idx + 1'b1;
                            end
                        end
                    end
                    LD_THR: begin
                        if (xfer) begin
                            sh_c[cls_idx] <= byte_i;
`ifdef LDA_LOADER_CSUM_EN
                            acc <= acc_next;
`endif
                            if (cls_idx == CLS_LAST) begin
                                cls_idx <= '0;
`ifdef LDA_LOADER_CSUM_EN
                                state   <= LD_CSUM;
`else
                                state       <= LD_COMMIT;
                                ready_o     <= 1'b0;
                                load_done_o <= 1'b1;
`endif
                            end else begin
                                cls_idx <= cls_idx + 1'b1;
                            end
                        end
                    end
`ifdef LDA_LOADER_CSUM_EN
                    LD_CSUM: begin
                        if (xfer) begin
                            if (acc_next == '0) begin
                                state       <= LD_COMMIT;
                                ready_o     <= 1'b0;
                                load_done_o <= 1'b1;
                            end else begin
                                state      <= LD_IDLE;
                                load_err_o <= 1'b1;
                            end
                        end
                    end
`endif
                    LD_COMMIT: begin
                        w_o          <= sh_w;
                        c_o          <= sh_c;
                        coef_valid_o <= 1'b1;
                        state        <= LD_IDLE;
                    end
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lda_coef_loader.sv
// Self-checking bench for lda_coef_loader: vector table of frames plus scoreboarded commit/error
// events, with hand-written back-pressure, clear and mid-frame reset sequences.
module tb_lda_coef_loader;
    import lda_pkg::*;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    logic clear_i = 1'b0;
    logic valid_i = 1'b0;
    T     byte_i = '0;
    logic ready_o, coef_valid_o, busy_o, load_done_o, load_err_o;
    T     w_o [DIMS][CLASSES];
    T     c_o [CLASSES];

    lda_coef_loader dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .clear_i      (clear_i),
        .byte_i       (byte_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .w_o          (w_o),
        .c_o          (c_o),
        .coef_valid_o (coef_valid_o),
        .busy_o       (busy_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic is_err;
        T     w [N_WGT];
        T     c [CLASSES];
    } ev_t;

    typedef struct {
        T     w0;
        T     wstep;
        T     c0;
        logic bad;
        logic junk;
        T     e_w00;
        T     e_w50;
        T     e_w01;
        T     e_c2;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    ev_t  sb_q [$];
    ev_t  mon_e;
    T     exp_w [N_WGT];   // model of active bank, index = class*DIMS + dim
    T     exp_c [CLASSES];
    logic pending = 1'b0;
    logic bp_mode = 1'b0;
    vec_t vecs [$];
    vec_t v;
    T     fw [N_WGT];
    T     fc [CLASSES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < N_WGT; k++)
            check($sformatf("%s w[%0d][%0d]", tag, k % DIMS, k / DIMS),
                  32'(w_o[k % DIMS][k / DIMS]), 32'(exp_w[k]));
        for (int j = 0; j < CLASSES; j++)
            check($sformatf("%s c[%0d]", tag, j), 32'(c_o[j]), 32'(exp_c[j]));
    endtask

    // Event monitor: pops the scoreboard on each pulse; commits are checked one cycle later.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            exp_w   = '{default: '0};
            exp_c   = '{default: '0};
            pending = 1'b0;
        end else begin
            if (pending) begin
                check_bank("commit");
                check("ready after commit", 32'(ready_o), 32'd1);
                pending = 1'b0;
            end
            if (load_done_o || load_err_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected event", 32'({load_done_o, load_err_o}), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("event kind", 32'({load_done_o, load_err_o}),
                          mon_e.is_err ? 32'd1 : 32'd2);
                    if (!mon_e.is_err) begin
                        exp_w   = mon_e.w;
                        exp_c   = mon_e.c;
                        pending = 1'b1;
                        check("ready in commit", 32'(ready_o), 32'd0);
                    end else begin
                        check_bank("after err");
                    end
                end
            end
        end
    end

    task automatic send_byte(input T b, input logic may_gap);
        int   n = 0;
        logic ok;
        if (bp_mode && may_gap && $urandom_range(0, 1) == 1) begin
            valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk_i);
                #1;
            end
        end
        byte_i  = b;
        valid_i = 1'b1;
        forever begin
            ok = ready_o;
            @(posedge clk_i);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                check("handshake timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_frame(input T w [N_WGT], input T c [CLASSES], input logic bad);
        T    sum;
        T    cs;
        ev_t e;
        e.is_err = bad;
        e.w      = w;
        e.c      = c;
        sum = SYNC;
        for (int k = 0; k < N_WGT; k++) sum = sum + w[k];
        for (int j = 0; j < CLASSES; j++) sum = sum + c[j];
        cs = 8'h00 - sum;
        if (bad) cs = cs + 8'd1;
        send_byte(SYNC, 1'b0);
        for (int k = 0; k < N_WGT; k++) send_byte(w[k], 1'b1);
        for (int j = 0; j < CLASSES - 1; j++) send_byte(c[j], 1'b1);
`ifdef LDA_LOADER_CSUM_EN
        send_byte(c[CLASSES-1], 1'b1);
        sb_q.push_back(e);
        send_byte(cs, 1'b1);
`else
        sb_q.push_back(e);
        send_byte(c[CLASSES-1], 1'b1);
`endif
        valid_i = 1'b0;
    endtask

    task automatic make_frame(input T w0, input T wstep, input T c0);
        for (int k = 0; k < N_WGT; k++) fw[k] = w0 + T'(k) * wstep;
        for (int j = 0; j < CLASSES; j++) fc[j] = c0 + T'(j);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || pending) && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n >= 200) check("event timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs.push_back('{8'd1, 8'd1, 8'd20, 1'b0, 1'b0, 8'd1, 8'd6, 8'd7, 8'd22});
`ifdef LDA_LOADER_CSUM_EN
        vecs.push_back('{8'd1, 8'd1, 8'd20, 1'b1, 1'b0, 8'd1, 8'd6, 8'd7, 8'd22});
`endif
        vecs.push_back('{8'd1, 8'd1, 8'd20, 1'b0, 1'b1, 8'd1, 8'd6, 8'd7, 8'd22});
        vecs.push_back('{8'hF0, 8'd7, 8'hFE, 1'b0, 1'b0, 8'hF0, 8'h13, 8'h1A, 8'h00});
        vecs.push_back('{8'hA5, 8'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA7});

        // Reset state
        #1;
        check("rst ready", 32'(ready_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst coef_valid", 32'(coef_valid_o), 32'd0);
        check("rst pulses", 32'({load_done_o, load_err_o}), 32'd0);
        check("rst w[3][1]", 32'(w_o[3][1]), 32'd0);
        check("rst c[2]", 32'(c_o[2]), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        check("ready before first edge", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("ready after first edge", 32'(ready_o), 32'd1);

        // Table of frames
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            make_frame(v.w0, v.wstep, v.c0);
            if (v.junk) begin
                send_byte(8'h00, 1'b0);
                send_byte(8'hFF, 1'b0);
                check($sformatf("v%0d junk busy", i), 32'(busy_o), 32'd0);
            end
            send_frame(fw, fc, v.bad);
            wait_idle();
            check($sformatf("v%0d w[0][0]", i), 32'(w_o[0][0]), 32'(v.e_w00));
            check($sformatf("v%0d w[5][0]", i), 32'(w_o[5][0]), 32'(v.e_w50));
            check($sformatf("v%0d w[0][1]", i), 32'(w_o[0][1]), 32'(v.e_w01));
            check($sformatf("v%0d c[2]", i), 32'(c_o[2]), 32'(v.e_c2));
            check($sformatf("v%0d coef_valid", i), 32'(coef_valid_o), 32'd1);
            check($sformatf("v%0d busy", i), 32'(busy_o), 32'd0);
        end

        // Back-pressure, second frame offered during COMMIT
        bp_mode = 1'b1;
        make_frame(8'd2, 8'd2, 8'd40);
        send_frame(fw, fc, 1'b0);
        make_frame(8'd50, 8'd1, 8'd90);
        send_frame(fw, fc, 1'b0);
        wait_idle();
        bp_mode = 1'b0;
        check("bp w[5][2]", 32'(w_o[5][2]), 32'd67);
        check("bp c[0]", 32'(c_o[0]), 32'd90);

        // clear_i after 10 payload bytes
        send_byte(SYNC, 1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'h55, 1'b0);
        check("busy before clear", 32'(busy_o), 32'd1);
        clear_i = 1'b1;
        byte_i  = 8'h77;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        check("busy after clear", 32'(busy_o), 32'd0);
        check("active kept on clear", 32'(w_o[0][0]), 32'd50);
        check("coef_valid kept on clear", 32'(coef_valid_o), 32'd1);
        make_frame(8'h33, 8'd0, 8'h33);
        fc = '{default: 8'h33};
        send_frame(fw, fc, 1'b0);
        wait_idle();
        check("all33 w[4][2]", 32'(w_o[4][2]), 32'h33);
        check("all33 c[2]", 32'(c_o[2]), 32'h33);

        // Reset mid-WGT
        send_byte(SYNC, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(8'h11, 1'b0);
        valid_i = 1'b0;
        rstn_i  = 1'b0;
        #1;
        check("midrst w[0][0]", 32'(w_o[0][0]), 32'd0);
        check("midrst c[1]", 32'(c_o[1]), 32'd0);
        check("midrst coef_valid", 32'(coef_valid_o), 32'd0);
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst ready", 32'(ready_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("ready after midrst", 32'(ready_o), 32'd1);
        make_frame(8'd1, 8'd1, 8'd20);
        send_frame(fw, fc, 1'b0);
        wait_idle();
        check("reload w[5][0]", 32'(w_o[5][0]), 32'd6);
        check("reload coef_valid", 32'(coef_valid_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
